// File: rtl/acker_pkg.sv
// Shared widths, sensor codes and read-FSM encoding for the acquisition data-access block.
package acker_pkg;

  localparam int DATA_WIDTH_DFLT = 14;
  localparam int SENSOR_WIDTH    = 2;

  typedef enum logic [SENSOR_WIDTH-1:0] {
    SENSOR1 = 2'd0,
    SENSOR2 = 2'd1,
    SENSOR3 = 2'd2,
    SENSOR4 = 2'd3
  } sensor_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_OUT  = 1'b1
  } rd_state_e;

endpackage

// File: rtl/acker_sync_fifo.sv
// Power-of-two synchronous FIFO: storage, wrapping pointers and occupancy count.
// Head word is combinational; caller guarantees writes only when accepted and reads only when non-empty.
module acker_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_dat_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en_i, rd_en_i})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // When full, wr_ptr == rd_ptr: a same-cycle push overwrites the slot being popped, which is
  // safe because the head is read combinationally before the edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en_i) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/acker_data_access.sv
// Buffers tagged sensor samples for host reads; pop-to-rd_valid latency is one cycle.
// Producer is throttled by a registered ready with one spare slot; samples arriving when truly full are dropped and flagged.
module acker_data_access
  import acker_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int DEPTH      = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [DATA_WIDTH-1:0]              da_Data_in,
  input  logic                               da_Data_in_valid,
  input  logic [SENSOR_WIDTH-1:0]            da_sensor_type,
  output logic                               da_Ready_for_Data_in,
  input  logic                               rd_req,
  output logic [DATA_WIDTH+SENSOR_WIDTH-1:0] rd_data,
  output logic                               rd_valid,
  output logic [$clog2(DEPTH):0]             fill_level,
  output logic                               overflow,
  input  logic                               clear_overflow
);

  localparam int                ENTRY_W   = DATA_WIDTH + SENSOR_WIDTH;
  localparam int                CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  FULL_LVL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  READY_LVL = CNT_W'(DEPTH - 2);

  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;
  logic               ready_d;
  logic               overflow_d;

  rd_state_e          state_q;
  logic               ready_q;
  logic               overflow_q;
  logic               rd_valid_q;
  logic [ENTRY_W-1:0] rd_data_q;

  acker_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clock),
    .rst_i      (reset),
    .wr_en_i    (push),
    .wr_dat_i   ({da_sensor_type, da_Data_in}),
    .rd_en_i    (pop),
    .head_dat_o (head),
    .count_o    (count)
  );

  // A pop frees the slot that a same-cycle write at full would otherwise be refused.
  always_comb begin
    full       = (count == FULL_LVL);
    pop        = rd_req && (count != '0);
    push       = da_Data_in_valid && (!full || pop);
    drop       = da_Data_in_valid && full && !pop;
    count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
    ready_d    = (count_nxt <= READY_LVL);
    overflow_d = clear_overflow ? 1'b0 : (overflow_q | drop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RD_IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
      case (state_q)
        RD_IDLE: begin
          rd_valid_q <= pop;
          if (pop) begin
            rd_data_q <= head;
            state_q   <= RD_OUT;
          end
        end
        RD_OUT: begin
          // Another request here is served immediately for one word per cycle.
          rd_valid_q <= pop;
          if (pop) begin
            rd_data_q <= head;
            state_q   <= RD_OUT;
          end else begin
            state_q   <= RD_IDLE;
          end
        end
        default: begin
          rd_valid_q <= 1'b0;
          state_q    <= RD_IDLE;
        end
      endcase
    end
  end

  assign da_Ready_for_Data_in = ready_q;
  assign overflow             = overflow_q;
  assign rd_valid             = rd_valid_q;
  assign rd_data              = rd_data_q;
  assign fill_level           = count;

endmodule

// File: tb/tb_acker_data_access.sv
// Directed and randomized checks of acker_data_access against a queue-based reference model.
module tb_acker_data_access;

  localparam int DW    = 14;
  localparam int DEPTH = 16;

  logic          clock;
  logic          reset;
  logic [DW-1:0] da_Data_in;
  logic          da_Data_in_valid;
  logic [1:0]    da_sensor_type;
  logic          da_Ready_for_Data_in;
  logic          rd_req;
  logic [DW+1:0] rd_data;
  logic          rd_valid;
  logic [4:0]    fill_level;
  logic          overflow;
  logic          clear_overflow;

  acker_data_access #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock                (clock),
    .reset                (reset),
    .da_Data_in           (da_Data_in),
    .da_Data_in_valid     (da_Data_in_valid),
    .da_sensor_type       (da_sensor_type),
    .da_Ready_for_Data_in (da_Ready_for_Data_in),
    .rd_req               (rd_req),
    .rd_data              (rd_data),
    .rd_valid             (rd_valid),
    .fill_level           (fill_level),
    .overflow             (overflow),
    .clear_overflow       (clear_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Reference model state
  logic [15:0] q[$];
  logic        exp_valid;
  logic [15:0] exp_data;
  logic        exp_ovf;
  logic        exp_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fill_level", 32'(fill_level), 32'(q.size()));
    chk("rd_valid",   32'(rd_valid),   32'(exp_valid));
    chk("rd_data",    32'(rd_data),    32'(exp_data));
    chk("overflow",   32'(overflow),   32'(exp_ovf));
    chk("ready",      32'(da_Ready_for_Data_in), 32'(exp_rdy));
  endtask

  // One clock with the given inputs; model advances on the edge, outputs checked 1ns later.
  task automatic cyc(input logic v, input logic [1:0] s, input logic [DW-1:0] d,
                     input logic r, input logic c);
    logic pop;
    logic full;
    da_Data_in_valid = v;
    da_sensor_type   = s;
    da_Data_in       = d;
    rd_req           = r;
    clear_overflow   = c;
    @(posedge clock);
    if (reset) begin
      q.delete();
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_ovf   = 1'b0;
      exp_rdy   = 1'b1;
    end else begin
      pop       = r && (q.size() > 0);
      full      = (q.size() == DEPTH);
      exp_valid = pop;
      if (pop) exp_data = q.pop_front();
      if (v && (!full || pop)) q.push_back({s, d});
      if (c) exp_ovf = 1'b0;
      else if (v && full && !pop) exp_ovf = 1'b1;
      exp_rdy = (q.size() <= DEPTH - 2);
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 2'd0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), DW'($urandom()),
        1'($urandom_range(0, 1)), 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] sent[$];
    logic [15:0] recv[$];
    int          budget;
    logic        v;
    logic        r;

    reset = 1'b1;
    da_Data_in = '0; da_Data_in_valid = 1'b0; da_sensor_type = '0;
    rd_req = 1'b0; clear_overflow = 1'b0;

    // Reset state
    cyc(1'b1, 2'd1, 14'h0155, 1'b1, 1'b0);
    reset = 1'b0;
    chk("reset_fill",  32'(fill_level), 32'd0);
    chk("reset_ready", 32'(da_Ready_for_Data_in), 32'd1);
    chk("reset_rdval", 32'(rd_valid), 32'd0);

    // Two tagged writes, two reads
    cyc(1'b1, 2'd0, 14'h0123, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, 14'h3FFF, 1'b0, 1'b0);
    chk("two_wr_fill", 32'(fill_level), 32'd2);
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("rd0_data", 32'(rd_data), 32'h0123);
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("rd1_data", 32'(rd_data), 32'({2'd3, 14'h3FFF}));
    chk("rd1_fill", 32'(fill_level), 32'd0);
    idle();

    // Fill to DEPTH, overflow, then clear racing a drop
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 2'(i % 4), 14'(16'h0100 + i), 1'b0, 1'b0);
      if (i == DEPTH - 3) chk("ready_at_14", 32'(da_Ready_for_Data_in), 32'd1);
      if (i == DEPTH - 2) chk("ready_at_15", 32'(da_Ready_for_Data_in), 32'd0);
    end
    chk("full_fill", 32'(fill_level), 32'(DEPTH));
    cyc(1'b1, 2'd2, 14'h1111, 1'b0, 1'b0);
    chk("drop_ovf",  32'(overflow), 32'd1);
    chk("drop_fill", 32'(fill_level), 32'(DEPTH));
    cyc(1'b1, 2'd2, 14'h2222, 1'b0, 1'b1);
    chk("clr_vs_drop_ovf", 32'(overflow), 32'd0);
    cyc(1'b1, 2'd1, 14'h3333, 1'b0, 1'b0);

    // Write while full with simultaneous pop
    cyc(1'b1, 2'd0, 14'h0AAA, 1'b1, 1'b0);
    chk("full_wr_pop_fill", 32'(fill_level), 32'(DEPTH));
    chk("full_wr_pop_data", 32'(rd_data), 32'h0100);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("last_word", 32'(rd_data), 32'h0AAA);
    chk("drained", 32'(fill_level), 32'd0);
    cyc(1'b0, 2'd0, '0, 1'b0, 1'b1);

    // Read on empty; write+read at fill 1
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("empty_rd_valid", 32'(rd_valid), 32'd0);
    cyc(1'b1, 2'd1, 14'h0042, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 14'h0055, 1'b1, 1'b0);
    chk("fill1_wr_rd", 32'(fill_level), 32'd1);
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);
    idle();

    // Reset mid read burst
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'(i), 14'(16'h0200 + i), 1'b0, 1'b0);
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 2'd3, 14'h0777, 1'b1, 1'b0);
    reset = 1'b0;
    chk("mid_rst_fill",  32'(fill_level), 32'd0);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_ready", 32'(da_Ready_for_Data_in), 32'd1);
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("post_rst_valid", 32'(rd_valid), 32'd0);

    // 20 writes with interleaved reads, pointers wrap
    budget = 0;
    while ((sent.size() < 20 || recv.size() < 20) && budget < 300) begin
      v = (sent.size() < 20) && ($urandom_range(0, 2) != 0) && (q.size() < DEPTH);
      r = ($urandom_range(0, 2) == 0) || (sent.size() == 20);
      cyc(v, 2'($urandom_range(0, 3)), DW'($urandom()), r, 1'b0);
      if (v) sent.push_back({da_sensor_type, da_Data_in});
      if (rd_valid) recv.push_back(rd_data);
      budget++;
    end
    chk("wrap_count", 32'(recv.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      if (i < recv.size() && i < sent.size())
        chk("wrap_order", 32'(recv[i]), 32'(sent[i]));
    end

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc(1'($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), DW'($urandom()),
               1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 19) == 0));
    end

    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
